// File: rtl/blast_pkg.sv
// Shared types and constants for the seed-hit extension pipeline.
package blast_pkg;
  localparam int DDR_LINE_BITS = 512;
  localparam int SYM_BITS      = 2;
  localparam int SCORE_W       = 11;
  localparam int NUM_SYMS      = DDR_LINE_BITS / SYM_BITS;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SCORE, OUT} state_e;

  typedef struct packed {
    logic [31:0] start;
    logic [31:0] stop;
  } hit_t;
endpackage

// File: rtl/hit_fifo.sv
// Show-ahead hit FIFO; a push while full is accepted only alongside a pop.
module hit_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/hit_extend.sv
// Buffers seed hits, fetches each hit's DDR line and runs ungapped X-drop
// extension against the latched query, handing results to the comparator.
module hit_extend
  import blast_pkg::*;
#(
  parameter int HIT_FIFO_DEPTH   = 8,
  parameter int SYMS_PER_CYCLE   = 8,
  parameter int MATCH_SCORE      = 1,
  parameter int MISMATCH_PENALTY = 3,
  parameter int XDROP            = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hitTEST,
  input  logic [31:0]              locationStart,
  input  logic [31:0]              locationEnd,
  input  logic [DDR_LINE_BITS-1:0] query,
  input  logic                     queryValid,
  output logic                     ddr_rd,
  output logic [31:0]              readAdd,
  input  logic                     ddr_rd_done,
  input  logic                     ddr_rd_valid,
  input  logic [DDR_LINE_BITS-1:0] ddr_rd_data,
  input  logic                     rdNew,
  output logic                     scoreValid,
  output logic [SCORE_W-1:0]       maxScoreOut,
  output logic [31:0]              outAddress,
  output logic [31:0]              outEnd,
  output logic [15:0]              hitDropCnt
);
  state_e                   state_q;
  logic [DDR_LINE_BITS-1:0] query_q, line_q;
  hit_t                     hit_q, fifo_rdata;
  logic [11:0]              run_q, max_q, run_d, max_d;
  logic [7:0]               idx_q, sym_idx;
  logic                     xdrop_d;
  logic                     fifo_full, fifo_empty, pop;
  logic                     ddr_rd_q, score_valid_q;
  logic [31:0]              read_add_q, out_addr_q, out_end_q;
  logic [SCORE_W-1:0]       max_out_q;
  logic [15:0]              drop_cnt_q;

  assign pop = (state_q == IDLE) && !fifo_empty;

  hit_fifo #(.DEPTH(HIT_FIFO_DEPTH), .W(64)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (hitTEST),
    .pop_i  (pop),
    .wdata_i({locationStart, locationEnd}),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Symbols idx..idx+SYMS_PER_CYCLE-1 scored as one ripple chain per cycle.
  always_comb begin
    run_d   = run_q;
    max_d   = max_q;
    xdrop_d = 1'b0;
    sym_idx = idx_q;
    for (int k = 0; k < SYMS_PER_CYCLE; k++) begin
      sym_idx = idx_q + 8'(k);
      if (query_q[{sym_idx, 1'b0} +: SYM_BITS] == line_q[{sym_idx, 1'b0} +: SYM_BITS])
        run_d = run_d + 12'(MATCH_SCORE);
      else if (run_d >= 12'(MISMATCH_PENALTY))
        run_d = run_d - 12'(MISMATCH_PENALTY);
      else
        run_d = '0;
      if (run_d > max_d) max_d = (run_d > 12'd2047) ? 12'd2047 : run_d;
      if ((max_d > run_d) && (max_d - run_d > 12'(XDROP))) xdrop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      query_q       <= '0;
      line_q        <= '0;
      hit_q         <= '0;
      run_q         <= '0;
      max_q         <= '0;
      idx_q         <= '0;
      ddr_rd_q      <= 1'b0;
      read_add_q    <= '0;
      score_valid_q <= 1'b0;
      max_out_q     <= '0;
      out_addr_q    <= '0;
      out_end_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      if (queryValid && state_q == IDLE && fifo_empty) query_q <= query;
      if (hitTEST && fifo_full && !pop && drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
      case (state_q)
        IDLE: if (!fifo_empty) begin
          hit_q      <= fifo_rdata;
          ddr_rd_q   <= 1'b1;
          read_add_q <= {fifo_rdata.start[31:9], 9'b0};
          state_q    <= REQ;
        end
        REQ: if (ddr_rd_done) begin
          ddr_rd_q <= 1'b0;
          state_q  <= WAIT;
        end
        WAIT: if (ddr_rd_valid) begin
          line_q  <= ddr_rd_data;
          run_q   <= '0;
          max_q   <= '0;
          idx_q   <= '0;
          state_q <= SCORE;
        end
        SCORE: begin
          run_q <= run_d;
          max_q <= max_d;
          idx_q <= idx_q + 8'(SYMS_PER_CYCLE);
          if (xdrop_d || idx_q == 8'(NUM_SYMS - SYMS_PER_CYCLE)) begin
            score_valid_q <= 1'b1;
            max_out_q     <= max_d[SCORE_W-1:0];
            out_addr_q    <= hit_q.start;
            out_end_q     <= hit_q.stop;
            state_q       <= OUT;
          end
        end
        OUT: if (rdNew) begin
          score_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ddr_rd      = ddr_rd_q;
  assign readAdd     = read_add_q;
  assign scoreValid  = score_valid_q;
  assign maxScoreOut = max_out_q;
  assign outAddress  = out_addr_q;
  assign outEnd      = out_end_q;
  assign hitDropCnt  = drop_cnt_q;
endmodule

// File: doc/hit_extend.md
Name: hit_extend

Overview:
- Downstream stage of memInt (the seed-match memory interface).
- Buffers hit locations produced by memInt in a small FIFO.
- For each hit, fetches the 512-bit DDR line containing the hit and runs ungapped extension scoring (match/mismatch with X-drop) against the latched 512-bit query.
- Presents maxScoreOut/outAddress to the comparator, which acknowledges each result with rdNew.

Parameters:
HIT_FIFO_DEPTH, 8, hit FIFO entries (power of 2)
SYMS_PER_CYCLE, 8, 2-bit nucleotide symbols scored per cycle (divides 256)
MATCH_SCORE, 1, added per matching symbol
MISMATCH_PENALTY, 3, subtracted per mismatching symbol
XDROP, 10, extension stops when max minus running score exceeds this

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
hitTEST  input  1  one-cycle hit pulse from memInt
locationStart  input  32  hit start bit address
locationEnd  input  32  hit end bit address
query  input  512  query, 256 symbols, symbol i = bits [2i+1:2i]
queryValid  input  1  load query
ddr_rd  output  1  DDR read request
readAdd  output  32  DDR bit address, 512-aligned
ddr_rd_done  input  1  request accepted
ddr_rd_valid  input  1  read data beat valid
ddr_rd_data  input  512  read data
rdNew  input  1  comparator consumed current result
scoreValid  output  1  result valid
maxScoreOut  output  11  best extension score
outAddress  output  32  locationStart of scored hit
outEnd  output  32  locationEnd of scored hit
hitDropCnt  output  16  hits dropped on full FIFO, saturating

Behaviour:
- Reset (rst low, async): all outputs 0, FIFO empty, query register 0, FSM IDLE.
- Query register:
  - Loads on queryValid only in IDLE with FIFO empty.
  - Ignored otherwise.
- FIFO:
  - Push on hitTEST of {locationStart, locationEnd}.
  - When full, a push is accepted only if a pop occurs in the same cycle; otherwise the hit is dropped and hitDropCnt increments, saturating at 16'hFFFF.
  - Pop occurs on the IDLE->REQ transition.
- FSM:
  - IDLE: if FIFO not empty, pop and go to REQ.
  - REQ:
    - ddr_rd=1, readAdd = {start[31:9], 9'b0}.
    - Held until ddr_rd_done=1 (may be the same cycle), then WAIT.
  - WAIT:
    - ddr_rd=0.
    - On ddr_rd_valid, capture ddr_rd_data, clear running=0 and max=0, set idx=0, go to SCORE.
  - SCORE:
    - Each cycle processes symbols idx..idx+SYMS_PER_CYCLE-1 in ascending order, as a sequential combinational chain.
    - Match: running += MATCH_SCORE. Mismatch: running -= MISMATCH_PENALTY, floored at 0.
    - max tracks the highest running value, saturating at 2047.
    - After any symbol where max - running > XDROP, stop at the end of the current cycle.
    - Otherwise go to OUT after symbol 255 (256/SYMS_PER_CYCLE cycles).
  - OUT:
    - scoreValid=1 with maxScoreOut, outAddress and outEnd stable.
    - On rdNew=1, drop scoreValid and go to IDLE.
- Latency from pop to scoreValid: 1 (REQ, done in the same cycle) + DDR latency + at most 256/SYMS_PER_CYCLE cycles + 1.
- ddr_rd_valid outside WAIT is ignored.
- rdNew outside OUT is ignored.
- Reset mid-read: the outstanding beat arrives in IDLE and is ignored.
- Running score width is 12 bits internally; maxScoreOut is 11 bits, saturated.

Decomposition:
- Shared package blast_pkg:
  - FSM state enum (IDLE, REQ, WAIT, SCORE, OUT).
  - DDR_LINE_BITS=512, SYM_BITS=2, SCORE_W=11.
  - Hit record typedef {start, end}.
- One sub-module: hit_fifo (parameterised depth, push/pop/full/empty, width 64).
- Scoring chain stays inline in hit_extend.

Test Plan:
- Query 'h1234abcd; hit at location 0; ddr[0] = 'h1234abcd (identical line) -> all 256 symbols match, scoreValid with maxScoreOut=256, outAddress=0, after 32 SCORE cycles.
- Same query; hit at location 2048; line all ones -> only symbols 1, 3, 4, 10 match; maxScoreOut=2; no X-drop; outAddress=2048.
- Line equal to query for symbols 0-99, complemented for symbols 100-255 -> running reaches 100, X-drop after the 4th mismatch (symbol 103, running 88); SCORE ends in cycle 13; maxScoreOut=100.
- rdNew held low; 10 back-to-back hitTEST pulses -> 1 hit in engine, 8 in FIFO, hitDropCnt=1.
- Release rdNew -> 9 results in push order.
- rst low while in WAIT -> all outputs 0 immediately.
- A ddr_rd_valid beat after reset release -> ignored; no scoreValid.
- queryValid while SCORE is active -> query unchanged; the current result matches the old query.
